// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the arbiter state encoding.
// Holds the 640x480 geometry, address/data widths and the clear-sequencer
// states used by frame_buffer_arbiter.
package fb_pkg;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;
   localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;
   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } arb_state_t;

   // Plain-vector aliases of the states for code that keeps state in a
   // logic [1:0] register.
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_DRAIN = DRAIN;
   localparam logic [1:0] ST_CLEAR = CLEAR;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Pixel-writer handshake bundle between the edge-detection pipeline and the
// frame-buffer arbiter.
//   wr_valid  writer offers a pixel
//   wr_ready  arbiter accepts the pixel this cycle
//   wr_addr   frame-buffer address of the pixel
//   wr_data   pixel value
// master = writer side, slave = arbiter side.
interface frame_buffer_arbiter_if #(
   parameter int ADDR_W = fb_pkg::ADDR_W,
   parameter int DATA_W = fb_pkg::DATA_W
);

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/fb_write_fifo.sv
// Synchronous write-buffer FIFO holding {address, data} pixel writes until
// the arbiter finds a free BRAM cycle.
//   video_clk, reset_n     clock and synchronous active-low reset
//   push, push_data        enqueue (ignored when full)
//   pop, pop_data          dequeue; pop_data is the current head (show-ahead)
//   full, empty, level     occupancy status
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fb_write_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 22
) (
   input  logic                     video_clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign full     = (level == (PTR_W+1)'(DEPTH));
   assign empty    = (level == '0);
   assign pop_data = mem[rd_ptr];

   // Storage array; contents need no reset because level gates every read.
   always_ff @(posedge video_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy; a push and pop in the same cycle cancel out.
   always_ff @(posedge video_clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares the single-port frame-buffer BRAM between the VGA display reader and
// the edge-detection pixel writer, and sequences whole-frame clears.
// Display reads always win the port; buffered writes and clear writes use
// only the cycles the display leaves free.
//   video_clk, reset_n          pixel clock, synchronous active-low reset
//   disp_req/disp_addr          display read request
//   disp_data/disp_valid        read return, BRAM_LAT+1 cycles after request
//   wr_bus (slave)              writer handshake (valid/ready/addr/data)
//   clear_req                   pulse starting a frame clear
//   clear_busy/clear_done       clear in progress / completion pulse
//   fifo_level                  write-buffer occupancy
//   bram_addr/din/we/dout       BRAM port
module frame_buffer_arbiter #(
   parameter int                 ADDR_W      = fb_pkg::ADDR_W,
   parameter int                 DATA_W      = fb_pkg::DATA_W,
   parameter int                 FB_SIZE     = fb_pkg::FB_SIZE,
   parameter int                 FIFO_DEPTH  = 8,
   parameter int                 BRAM_LAT    = 1,
   parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
   input  logic                            video_clk,
   input  logic                            reset_n,
   input  logic                            disp_req,
   input  logic [ADDR_W-1:0]               disp_addr,
   output logic [DATA_W-1:0]               disp_data,
   output logic                            disp_valid,
   frame_buffer_arbiter_if.slave           wr_bus,
   input  logic                            clear_req,
   output logic                            clear_busy,
   output logic                            clear_done,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic [ADDR_W-1:0]               bram_addr,
   output logic [DATA_W-1:0]               bram_din,
   output logic                            bram_we,
   input  logic [DATA_W-1:0]               bram_dout
);

   import fb_pkg::*;

   localparam int                ENTRY_W   = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

   logic [1:0]         state;
   logic [ADDR_W-1:0]  clear_cnt;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               clear_wr;
   logic [ENTRY_W-1:0] head;
   logic [BRAM_LAT:0]  req_pipe;

   // New writes are refused while a clear is pending or running so the
   // clear cannot be overwritten by stale traffic; reset_n gates it too so
   // nothing is accepted during reset.
   assign wr_bus.wr_ready = !fifo_full && (state == ST_IDLE) && reset_n;
   assign push            = wr_bus.wr_valid && wr_bus.wr_ready;
   assign clear_wr        = !disp_req && (state == ST_CLEAR);
   assign pop             = !disp_req && (state != ST_CLEAR) && !fifo_empty;
   assign clear_busy      = (state != ST_IDLE);
   assign disp_valid      = req_pipe[BRAM_LAT];

   fb_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .video_clk (video_clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ({wr_bus.wr_addr, wr_bus.wr_data}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // BRAM port mux: display read, then clear write, then buffered write.
   // With no writer the address follows the display so reads stay cheap.
   always_comb begin
      bram_addr = disp_addr;
      bram_din  = '0;
      bram_we   = 1'b0;
      if (disp_req) begin
         bram_addr = disp_addr;
      end else if (state == ST_CLEAR) begin
         bram_addr = clear_cnt;
         bram_din  = CLEAR_VALUE;
         bram_we   = 1'b1;
      end else if (!fifo_empty) begin
         bram_addr = head[ENTRY_W-1:DATA_W];
         bram_din  = head[DATA_W-1:0];
         bram_we   = 1'b1;
      end
   end

   // Clear sequencer: drain pending writes, then sweep every address once,
   // advancing only when the display actually left the port free.
   always_ff @(posedge video_clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         clear_cnt  <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clear_req) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) begin
                  state     <= ST_CLEAR;
                  clear_cnt <= '0;
               end
            end
            ST_CLEAR: begin
               if (clear_wr) begin
                  if (clear_cnt == LAST_ADDR) begin
                     state      <= ST_IDLE;
                     clear_cnt  <= '0;
                     clear_done <= 1'b1;
                  end else begin
                     clear_cnt <= clear_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read return: request flag delayed to line up with the registered BRAM
   // output, so a new read can be issued every cycle.
   always_ff @(posedge video_clk) begin
      if (!reset_n) begin
         req_pipe  <= '0;
         disp_data <= '0;
      end else begin
         req_pipe[0] <= disp_req;
         for (int i = 1; i <= BRAM_LAT; i++) begin
            req_pipe[i] <= req_pipe[i-1];
         end
         disp_data <= bram_dout;
      end
   end

endmodule
